loadable_counter_param: RTL

LOADABLE_COUNTER_PARAM -- requirements
Module: loadable_counter_param

---
 rtl/loadable_counter_param.sv | 132 +++++++++++++
 1 files changed

// File: rtl/loadable_counter_param.sv
// Loadable up/down counter with wrap, saturate and one-shot modes.
// Latency: count, tc, ovf and done are registered. Load or step takes effect on the next rising edge.
// Backpressure: none. en gates counting. load and reset take priority over en every cycle.
//
// Ports:
//   clk, reset        rising-edge clock; synchronous active-high reset
//   load, data        load min(data, limit) into count; clears ovf and done
//   en, up            count enable and direction (1 = up, 0 = down)
//   limit             inclusive upper bound of the count range
//   mode              00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   count, tc         counter value; one-cycle pulse after each boundary event
//   ovf, done         sticky wrap flag; one-shot completion flag
module loadable_counter_param #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] limit,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             done
);

  localparam logic [WIDTH-1:0] RST_CNT  = RST_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [1:0]       MODE_SAT = 2'b01;
  localparam logic [1:0]       MODE_ONE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t state;
  state_t state_nxt;

  logic oneshot;
  logic wrap_mode;
  logic run_ok;
  logic at_bound;
  logic step_ok;
  logic bound_evt;

  // The reserved encoding 11 behaves as wrap.
  assign oneshot   = (mode == MODE_ONE);
  assign wrap_mode = !oneshot && (mode != MODE_SAT);

  // ">=" rather than "==" on the up side: if limit is lowered below the
  // current count, the next up step is treated as a boundary and never
  // rolls through the top of the WIDTH-bit range.
  assign at_bound  = up ? (count >= limit) : (count == '0);

  assign step_ok   = en && !load && run_ok;
  assign bound_evt = step_ok && at_bound;

  // FSM state register. Leaving one-shot mode parks the FSM in IDLE, so
  // re-entering one-shot always waits for a fresh load.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    if (!oneshot) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (load) state_nxt = S_RUN;
        S_RUN: begin
          if (load) begin
            state_nxt = S_RUN;
          end else if (bound_evt) begin
            state_nxt = S_DONE;
          end
        end
        S_DONE: if (load) state_nxt = S_RUN;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM outputs. Outside one-shot mode the FSM never gates counting.
  // In IDLE and DONE it blocks en.
  always_comb begin
    run_ok = 1'b1;
    done   = 1'b0;
    if (oneshot) begin
      run_ok = (state == S_RUN);
    end
    if (state == S_DONE) begin
      done = 1'b1;
    end
  end

  // Counter datapath: reset > load > enabled step > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= RST_CNT;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= (data > limit) ? limit : data;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (step_ok) begin
      tc <= at_bound;
      if (!at_bound) begin
        count <= up ? (count + ONE) : (count - ONE);
      end else if (wrap_mode) begin
        count <= up ? '0 : limit;
        ovf   <= 1'b1;
      end
      // Saturate and one-shot hold count at the boundary.
    end else begin
      tc <= 1'b0;
    end
  end

endmodule
